// File: rtl/dma_xfer_sequencer.sv
// Sequences one host DMA transfer: loads realignment counts, splits the transfer into PCI bursts
// and generates word-position flags. Define DMA_SEQ_4K_SPLIT_EN to keep bursts inside 4 KB host pages.
module dma_xfer_sequencer #(
    parameter int MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        dir_rd,
    input  logic [31:0] host_addr,
    input  logic [10:0] byte_len,
    input  logic        cnet_reprog,
    input  logic        burst_ack,
    input  logic        burst_done,
    input  logic        dma_data_vld,
    input  logic        read_from_cnet,
    output logic        busy,
    output logic        done,
    output logic        abort,
    output logic        err,
    output logic        ld_xfer_cnt,
    output logic        xfer_is_rd,
    output logic [1:0]  non_aligned_bytes,
    output logic [8:0]  xfer_cnt_start,
    output logic [8:0]  to_cnet_cnt_start,
    output logic        first_word_pci,
    output logic        last_word_pci,
    output logic        last_word_from_cnet,
    output logic        burst_req,
    output logic [31:0] burst_addr,
    output logic [8:0]  burst_words
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_XFER,
        S_DRAIN
    } state_t;

    localparam logic [10:0] MAX_BURST_W = 11'(MAX_BURST);

    state_t      state_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        abort_reg;
    logic        err_reg;
    logic        ld_reg;
    logic        is_rd_reg;
    logic [1:0]  nab_reg;
    logic [8:0]  xfer_cnt_reg;
    logic [8:0]  cnet_cnt_reg;
    logic        burst_req_reg;
    logic [31:0] burst_addr_reg;
    logic [8:0]  burst_words_reg;
    logic [8:0]  pci_rem_reg;
    logic [8:0]  pci_cnt_reg;
    logic [8:0]  cnet_rem_reg;

    logic [8:0]  pci_rem_next;
    logic [8:0]  pci_cnt_next;
    logic [8:0]  cnet_rem_next;
    logic [8:0]  burst_words_next;
    logic [10:0] size_w;
    logic [8:0]  xfer_words;
    logic [8:0]  cnet_words;
    logic        len_ok;
    logic        drain_ok;

    // Worst case is 3 + 2040 + 3 = 2046, so 11-bit sums never overflow before the shift.
    assign xfer_words = 9'(({9'd0, host_addr[1:0]} + byte_len + 11'd3) >> 2);
    assign cnet_words = 9'((byte_len + 11'd3) >> 2);
    assign len_ok     = (byte_len != 11'd0) && (byte_len <= 11'd2040);
    assign drain_ok   = is_rd_reg ? (cnet_rem_reg == 9'd0) : 1'b1;

    always_comb begin
        pci_rem_next  = pci_rem_reg;
        pci_cnt_next  = pci_cnt_reg;
        cnet_rem_next = cnet_rem_reg;
        if (busy_reg && dma_data_vld) begin
            if (pci_rem_reg != 9'd0) pci_rem_next = pci_rem_reg - 9'd1;
            if (pci_cnt_reg != 9'h1FF) pci_cnt_next = pci_cnt_reg + 9'd1;
        end
        if (busy_reg && is_rd_reg && read_from_cnet && (cnet_rem_reg != 9'd0))
            cnet_rem_next = cnet_rem_reg - 9'd1;
    end

    // Size of the next burst, evaluated against the address the burst will start at.
`ifdef DMA_SEQ_4K_SPLIT_EN
    logic [10:0] page_words;
    assign page_words = 11'((13'h1000 - {1'b0, burst_addr_reg[11:0]}) >> 2);
`endif

    always_comb begin
        size_w = {2'b00, pci_rem_next};
        if (size_w > MAX_BURST_W) size_w = MAX_BURST_W;
`ifdef DMA_SEQ_4K_SPLIT_EN
        if (size_w > page_words) size_w = page_words;
`endif
        burst_words_next = 9'(size_w);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            abort_reg       <= 1'b0;
            err_reg         <= 1'b0;
            ld_reg          <= 1'b0;
            is_rd_reg       <= 1'b0;
            nab_reg         <= 2'd0;
            xfer_cnt_reg    <= 9'd0;
            cnet_cnt_reg    <= 9'd0;
            burst_req_reg   <= 1'b0;
            burst_addr_reg  <= 32'd0;
            burst_words_reg <= 9'd0;
            pci_rem_reg     <= 9'd0;
            pci_cnt_reg     <= 9'd0;
            cnet_rem_reg    <= 9'd0;
        end else begin
            done_reg     <= 1'b0;
            abort_reg    <= 1'b0;
            err_reg      <= 1'b0;
            ld_reg       <= 1'b0;
            pci_rem_reg  <= pci_rem_next;
            pci_cnt_reg  <= pci_cnt_next;
            cnet_rem_reg <= cnet_rem_next;

            if (cnet_reprog && (state_reg != S_IDLE)) begin
                state_reg     <= S_IDLE;
                busy_reg      <= 1'b0;
                abort_reg     <= 1'b1;
                burst_req_reg <= 1'b0;
                pci_rem_reg   <= 9'd0;
                pci_cnt_reg   <= 9'd0;
                cnet_rem_reg  <= 9'd0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (start && !cnet_reprog) begin
                            if (len_ok) begin
                                state_reg      <= S_LOAD;
                                busy_reg       <= 1'b1;
                                ld_reg         <= 1'b1;
                                is_rd_reg      <= dir_rd;
                                nab_reg        <= host_addr[1:0];
                                xfer_cnt_reg   <= xfer_words;
                                cnet_cnt_reg   <= cnet_words;
                                burst_addr_reg <= {host_addr[31:2], 2'b00};
                                pci_rem_reg    <= xfer_words;
                                pci_cnt_reg    <= 9'd0;
                                cnet_rem_reg   <= cnet_words;
                            end else begin
                                err_reg <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        state_reg       <= S_REQ;
                        burst_req_reg   <= 1'b1;
                        burst_words_reg <= burst_words_next;
                    end
                    S_REQ: begin
                        if (burst_ack) begin
                            state_reg      <= S_XFER;
                            burst_req_reg  <= 1'b0;
                            burst_addr_reg <= burst_addr_reg + {21'd0, burst_words_reg, 2'b00};
                        end
                    end
                    S_XFER: begin
                        if (burst_done) begin
                            if (pci_rem_next != 9'd0) begin
                                state_reg       <= S_REQ;
                                burst_req_reg   <= 1'b1;
                                burst_words_reg <= burst_words_next;
                            end else begin
                                state_reg <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        // Writes spend one cycle here, giving the realignment buffer two cycles after burst_done.
                        if (drain_ok) begin
                            state_reg <= S_IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg     <= S_IDLE;
                        busy_reg      <= 1'b0;
                        burst_req_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy                = busy_reg;
    assign done                = done_reg;
    assign abort               = abort_reg;
    assign err                 = err_reg;
    assign ld_xfer_cnt         = ld_reg;
    assign xfer_is_rd          = is_rd_reg;
    assign non_aligned_bytes   = nab_reg;
    assign xfer_cnt_start      = xfer_cnt_reg;
    assign to_cnet_cnt_start   = cnet_cnt_reg;
    assign first_word_pci      = busy_reg && (pci_cnt_reg == 9'd0);
    assign last_word_pci       = (pci_rem_reg == 9'd1);
    assign last_word_from_cnet = (cnet_rem_reg == 9'd1);
    assign burst_req           = burst_req_reg;
    assign burst_addr          = burst_addr_reg;
    assign burst_words         = burst_words_reg;

endmodule

// File: tb/tb_dma_xfer_sequencer.sv
// Self-checking bench for dma_xfer_sequencer: table vectors, abort sequences and randomized transfers
// checked against a burst-plan / word-count reference model.
module tb_dma_xfer_sequencer;

    localparam int MAX_BURST = 16;
    localparam int PH_REQ   = 0;
    localparam int PH_ACKED = 1;
    localparam int PH_DATA  = 2;
    localparam int PH_DRAIN = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, dir_rd, cnet_reprog, burst_ack, burst_done, dma_data_vld, read_from_cnet;
    logic [31:0] host_addr;
    logic [10:0] byte_len;
    logic        busy, done, abort, err, ld_xfer_cnt, xfer_is_rd;
    logic [1:0]  non_aligned_bytes;
    logic [8:0]  xfer_cnt_start, to_cnet_cnt_start;
    logic        first_word_pci, last_word_pci, last_word_from_cnet;
    logic        burst_req;
    logic [31:0] burst_addr;
    logic [8:0]  burst_words;

    always #5 clk = ~clk;

    dma_xfer_sequencer #(.MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset), .start(start), .dir_rd(dir_rd), .host_addr(host_addr),
        .byte_len(byte_len), .cnet_reprog(cnet_reprog), .burst_ack(burst_ack),
        .burst_done(burst_done), .dma_data_vld(dma_data_vld), .read_from_cnet(read_from_cnet),
        .busy(busy), .done(done), .abort(abort), .err(err), .ld_xfer_cnt(ld_xfer_cnt),
        .xfer_is_rd(xfer_is_rd), .non_aligned_bytes(non_aligned_bytes),
        .xfer_cnt_start(xfer_cnt_start), .to_cnet_cnt_start(to_cnet_cnt_start),
        .first_word_pci(first_word_pci), .last_word_pci(last_word_pci),
        .last_word_from_cnet(last_word_from_cnet), .burst_req(burst_req),
        .burst_addr(burst_addr), .burst_words(burst_words)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; cnet_reprog = 0; burst_ack = 0; burst_done = 0;
        dma_data_vld = 0; read_from_cnet = 0;
    endtask

    // Reference burst plan: greedy split by remaining words, MAX_BURST and (optionally) 4 KB pages.
    int unsigned pl_addr[$];
    int          pl_words[$];

    function automatic void make_plan(input logic [31:0] addr, input int words);
        int unsigned a;
        int rem, n;
        pl_addr.delete();
        pl_words.delete();
        a = addr & 32'hFFFF_FFFC;
        rem = words;
        while (rem > 0) begin
            n = (rem > MAX_BURST) ? MAX_BURST : rem;
`ifdef DMA_SEQ_4K_SPLIT_EN
            if (n > int'((4096 - (a % 4096)) / 4)) n = int'((4096 - (a % 4096)) / 4);
`endif
            pl_addr.push_back(a);
            pl_words.push_back(n);
            a = a + 4 * n;
            rem = rem - n;
        end
    endfunction

    // abort_mode: 0 none, 1 cnet_reprog during XFER, 2 cnet_reprog during REQ.
    task automatic run_xfer(input logic [31:0] addr, input int len, input logic rd,
                            input int exp_xfer, input int exp_cnet,
                            input int abort_mode, input bit rnd_start);
        int words, prem, crem, wdone, phase, data_left, cyc, bd_cyc, exp_done, bidx;
        bit fin;
        words = (int'(addr[1:0]) + len + 3) / 4;
        make_plan(addr, words);
        clear_inputs();
        host_addr = addr; byte_len = 11'(len); dir_rd = rd; start = 1;
        tick();
        start = 0;
        check("load_strobe", ld_xfer_cnt, 1);
        check("load_busy", busy, 1);
        check("xfer_cnt_start", xfer_cnt_start, exp_xfer);
        check("to_cnet_cnt_start", to_cnet_cnt_start, exp_cnet);
        check("non_aligned_bytes", non_aligned_bytes, addr[1:0]);
        check("xfer_is_rd", xfer_is_rd, rd);
        check("load_no_req", burst_req, 0);
        prem = words; crem = (len + 3) / 4; wdone = 0;
        phase = PH_REQ; data_left = 0; cyc = 0; bd_cyc = -10; exp_done = -1; bidx = 0; fin = 0;
        tick();
        while (!fin && cyc < 6000) begin
            check("first_word_pci", first_word_pci, (wdone == 0));
            check("last_word_pci", last_word_pci, (prem == 1));
            check("last_word_from_cnet", last_word_from_cnet, (crem == 1));
            if (phase == PH_DRAIN && exp_done < 0 && cyc >= bd_cyc + 1 && (!rd || crem == 0))
                exp_done = cyc + 1;
            check("done_timing", done, (cyc == exp_done));
            if (cyc == exp_done) begin
                check("busy_after_done", busy, 0);
                check("bursts_issued", bidx, pl_words.size());
                check("cnt_held", xfer_cnt_start, exp_xfer);
                fin = 1;
            end else begin
                check("busy", busy, 1);
                clear_inputs();
                if ((abort_mode == 1 && phase == PH_DATA && wdone >= 2) ||
                    (abort_mode == 2 && phase == PH_REQ)) begin
                    cnet_reprog = 1; burst_ack = 1; burst_done = 1; dma_data_vld = 1;
                    tick();
                    clear_inputs();
                    check("abort_pulse", abort, 1);
                    check("abort_busy", busy, 0);
                    check("abort_no_done", done, 0);
                    check("abort_req_drop", burst_req, 0);
                    check("abort_last_pci", last_word_pci, 0);
                    check("abort_last_cnet", last_word_from_cnet, 0);
                    check("abort_first_pci", first_word_pci, 0);
                    tick();
                    check("abort_one_cycle", abort, 0);
                    check("abort_idle", busy, 0);
                    return;
                end
                if (phase == PH_ACKED) begin
                    check("req_drop_after_ack", burst_req, 0);
                    phase = PH_DATA;
                end
                case (phase)
                    PH_REQ: begin
                        check("burst_req", burst_req, 1);
                        check("burst_addr", burst_addr, pl_addr[bidx]);
                        check("burst_words", burst_words, pl_words[bidx]);
                        if ($urandom % 2 == 0) begin
                            burst_ack = 1;
                            burst_done = 1'($urandom % 2);
                            data_left = pl_words[bidx];
                            bidx++;
                            phase = PH_ACKED;
                        end
                    end
                    PH_DATA: begin
                        if (data_left > 0) begin
                            if ($urandom % 4 != 0) begin
                                dma_data_vld = 1;
                                data_left--;
                            end
                            burst_ack = 1'($urandom % 8 == 0);
                        end else begin
                            burst_done = 1;
                            bd_cyc = cyc;
                            phase = (bidx < pl_words.size()) ? PH_REQ : PH_DRAIN;
                        end
                    end
                    default: ;
                endcase
                read_from_cnet = 1'($urandom % 2);
                if (rnd_start && ($urandom % 8 == 0)) begin
                    start = 1;
                    host_addr = $urandom;
                    byte_len = 11'($urandom_range(1, 2040));
                    dir_rd = 1'($urandom % 2);
                end
                tick();
                cyc++;
                if (dma_data_vld) begin
                    if (prem > 0) prem--;
                    wdone++;
                end
                if (read_from_cnet && rd && crem > 0) crem--;
                clear_inputs();
            end
        end
        if (!fin) check("xfer_timeout", 0, 1);
    endtask

    task automatic bad_start(input logic [31:0] addr, input int len);
        clear_inputs();
        host_addr = addr; byte_len = 11'(len); dir_rd = 1; start = 1;
        tick();
        start = 0;
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        check("err_no_load", ld_xfer_cnt, 0);
        tick();
        check("err_one_cycle", err, 0);
        check("err_stays_idle", busy, 0);
        check("err_no_load2", ld_xfer_cnt, 0);
    endtask

    typedef struct {
        logic [31:0] addr;
        int          len;
        logic        rd;
        logic        exp_err;
        int          exp_xfer;
        int          exp_cnet;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{32'h0000_1000,   64, 1'b1, 1'b0,  16,  16};
        vecs[1] = '{32'h0000_2003,   10, 1'b0, 1'b0,   4,   3};
        vecs[2] = '{32'h0000_0000, 2040, 1'b1, 1'b0, 510, 510};
        vecs[3] = '{32'h0000_0FF8,   32, 1'b0, 1'b0,   8,   8};
        vecs[4] = '{32'h0000_1001,    1, 1'b1, 1'b0,   1,   1};
        vecs[5] = '{32'h0000_0003, 2040, 1'b0, 1'b0, 511, 510};
        vecs[6] = '{32'h0000_0002,    5, 1'b1, 1'b0,   2,   2};
        vecs[7] = '{32'h0000_4000,    0, 1'b1, 1'b1,   0,   0};
        vecs[8] = '{32'h0000_4000, 2041, 1'b1, 1'b1,   0,   0};
        vecs[9] = '{32'h0000_4000, 2047, 1'b0, 1'b1,   0,   0};

        clear_inputs();
        host_addr = 0; byte_len = 0; dir_rd = 0;
        reset = 1;
        repeat (3) tick();
        reset = 0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_abort", abort, 0);
        check("rst_err", err, 0);
        check("rst_ld", ld_xfer_cnt, 0);
        check("rst_req", burst_req, 0);
        check("rst_addr", burst_addr, 0);
        check("rst_words", burst_words, 0);
        check("rst_cnts", {xfer_cnt_start, to_cnet_cnt_start, non_aligned_bytes, xfer_is_rd}, 0);
        check("rst_flags", {first_word_pci, last_word_pci, last_word_from_cnet}, 0);

        for (int i = 0; i < 10; i++) begin
            $display("[TB] vector %0d addr=0x%08h len=%0d rd=%0d", i, vecs[i].addr, vecs[i].len, vecs[i].rd);
            if (vecs[i].exp_err)
                bad_start(vecs[i].addr, vecs[i].len);
            else
                run_xfer(vecs[i].addr, vecs[i].len, vecs[i].rd, vecs[i].exp_xfer, vecs[i].exp_cnet, 0, 0);
        end

        // cnet_reprog while idle does nothing.
        clear_inputs();
        cnet_reprog = 1;
        tick();
        cnet_reprog = 0;
        check("idle_reprog_abort", abort, 0);
        check("idle_reprog_busy", busy, 0);

        $display("[TB] abort during XFER, then a normal transfer");
        run_xfer(32'h0000_0040, 256, 1'b1, 64, 64, 1, 0);
        run_xfer(32'h0000_0044, 100, 1'b0, 25, 25, 0, 0);
        $display("[TB] abort during REQ, then a normal transfer");
        run_xfer(32'h0000_0081, 64, 1'b0, 17, 16, 2, 0);
        run_xfer(32'h0000_0FF0, 300, 1'b1, 75, 75, 0, 0);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] a;
            int l;
            logic r;
            a = $urandom;
            l = $urandom_range(1, 2040);
            r = 1'($urandom % 2);
            $display("[TB] random %0d addr=0x%08h len=%0d rd=%0d", i, a, l, r);
            run_xfer(a, l, r, (int'(a[1:0]) + l + 3) / 4, (l + 3) / 4, 0, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dma_xfer_sequencer.md
# dma_xfer_sequencer

Sequences a single host DMA transfer through the CPCI byte-realignment datapath. It accepts a host address, byte length and direction. It then:
- loads the realignment word counters and supplies `non_aligned_bytes`;
- splits the transfer into PCI bursts for the PCI master;
- generates the first/last-word flags the realignment path consumes.

It sits between the DMA register block (CPU-programmed descriptor) and the PCI master / realignment datapath.

## Interface
Parameters:
- `MAX_BURST`, default 16: maximum words per PCI burst; legal range 1..256.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle request to begin a transfer; sampled only in IDLE.
- `dir_rd` in 1: transfer direction; 1 = CNET to host memory (read), 0 = host memory to CNET (write).
- `host_addr` in 32: host byte address of the first byte.
- `byte_len` in 11: byte count; legal range 1..2040.
- `cnet_reprog` in 1: CNET reprogramming; aborts any transfer in progress.
- `burst_ack` in 1: PCI master accepted the current burst request.
- `burst_done` in 1: PCI master finished the current burst.
- `dma_data_vld` in 1: one PCI data word transferred.
- `read_from_cnet` in 1: one word taken from CNET.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse on completion.
- `abort` out 1: one-cycle pulse when a transfer is killed by `cnet_reprog`.
- `err` out 1: one-cycle pulse when `start` is rejected because of an illegal length.
- `ld_xfer_cnt` out 1: one-cycle counter-load strobe.
- `xfer_is_rd` out 1: latched `dir_rd`.
- `non_aligned_bytes` out 2: latched `host_addr[1:0]`.
- `xfer_cnt_start` out 9: PCI word count.
- `to_cnet_cnt_start` out 9: CNET word count.
- `first_word_pci`, `last_word_pci`, `last_word_from_cnet` out 1 each: word-position flags.
- `burst_req` out 1: burst request to the PCI master.
- `burst_addr` out 32: word-aligned burst start address.
- `burst_words` out 9: burst length in words.

## Operation
- Counts are computed at `start`, 11-bit arithmetic, truncated to 9 bits:
  - `xfer_cnt_start` = (`host_addr[1:0]` + `byte_len` + 3) >> 2
  - `to_cnet_cnt_start` = (`byte_len` + 3) >> 2
- Both counts are registered, along with `non_aligned_bytes`, `xfer_is_rd` and the word address `{host_addr[31:2],2'b00}`.
- A `start` with `byte_len` = 0 or > 2040 pulses `err`, and the block stays in IDLE.
- States: IDLE, LOAD, REQ, XFER, DRAIN.
  - IDLE: on a legal `start`, go to LOAD.
  - LOAD: assert `ld_xfer_cnt`, go to REQ.
  - REQ: `burst_req` = 1. On `burst_ack`, go to XFER.
  - XFER: on `burst_done`, if PCI words remain go to REQ, else go to DRAIN.
  - DRAIN:
    - read: wait until the CNET remaining count = 0;
    - write: wait exactly 2 cycles to let the realignment buffer flush;
    - then pulse `done` and go to IDLE.
- Burst length = min(PCI remaining, `MAX_BURST`, subject to Configuration). `burst_addr` advances by 4 × `burst_words` at each `burst_ack`.
- The PCI remaining counter decrements on `dma_data_vld` while busy.
- The CNET remaining counter decrements on `read_from_cnet` while busy and `xfer_is_rd` = 1. Both counters saturate at 0.
- Word-position flags:
  - `first_word_pci` = busy && (PCI words done = 0);
  - `last_word_pci` = (PCI remaining = 1);
  - `last_word_from_cnet` = (CNET remaining = 1).
- `cnet_reprog` in any non-IDLE state:
  - next state is IDLE;
  - `abort` pulses;
  - `burst_req` drops;
  - counters clear.
  - `cnet_reprog` has priority over `start`, `burst_ack` and `burst_done`.

## Timing
- All outputs reset to 0; state resets to IDLE.
- `start` at cycle N:
  - LOAD at N+1, with `ld_xfer_cnt` high and the count outputs valid;
  - `burst_req` first high at N+2.
- `burst_req`, `burst_addr` and `burst_words` are held stable until the cycle `burst_ack` is sampled high. `burst_req` drops the following cycle.
- `burst_ack` and `burst_done` in the same cycle in REQ: treated as ack only. `burst_done` is honoured only in XFER.
- `done` is registered: it pulses the cycle after the DRAIN exit condition is met. `busy` falls in that same cycle.
- A `start` while busy is ignored.
- Count and direction outputs hold their values until the next LOAD.

## Configuration
- `DMA_SEQ_4K_SPLIT_EN` defined: a burst never crosses a 4 KB host boundary. `burst_words` is additionally limited to (4096 − `burst_addr[11:0]`) >> 2.
- Undefined: no boundary limit; bursts are limited only by `MAX_BURST` and the remaining count.

## Test plan
- Aligned read: addr 0x1000, len 64, `MAX_BURST`=16 -> `xfer_cnt_start`=16, `to_cnet_cnt_start`=16, one burst of 16 at 0x1000, `done` after 16 CNET reads.
- Unaligned write: addr 0x2003, len 10 -> `non_aligned_bytes`=3, `xfer_cnt_start`=4, `to_cnet_cnt_start`=3; `first_word_pci` high only before the first `dma_data_vld`; `done` 2 cycles after `burst_done`.
- Multi-burst: addr 0x0, len 2040, `MAX_BURST`=16 -> 31 bursts of 16 and 1 of 14 (510 words); `burst_addr` steps by 0x40.
- 4K split (macro on): addr 0x0FF8, len 32 -> bursts of 2 words at 0x0FF8, then 6 words at 0x1000. Macro off -> a single burst of 8.
- Illegal length: `byte_len`=0 and `byte_len`=2041 -> `err` pulse, `busy` stays 0, no `ld_xfer_cnt`.
- Abort: `cnet_reprog` asserted in XFER -> `abort` pulse, IDLE next cycle, no `done`; a new `start` afterwards completes normally.
